// File: rtl/reg_snapshot_stack_if.sv
// Handshake and status bundle between a register file and its snapshot stack.
//
// master modport (register-file side):
//   backup     out  push dataIn this cycle
//   restore    out  pop the top snapshot this cycle
//   clearErr   out  clear the sticky overflow/underflow flags
//   dataIn     out  snapshot image to push
//   dataOut    in   registered popped snapshot
//   restoreOut in   one-cycle pulse, dataOut was updated
//   count      in   current occupancy
//   full       in   occupancy equals DEPTH
//   empty      in   occupancy is zero
//   overflow   in   sticky push-rejected / oldest-overwritten flag
//   underflow  in   sticky pop-on-empty flag
// slave modport: the same signals with directions reversed (the stack side).
interface reg_snapshot_stack_if #(
  parameter int WIDTH = 256,
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH + 1)
);
  logic             backup;
  logic             restore;
  logic             clearErr;
  logic [WIDTH-1:0] dataIn;
  logic [WIDTH-1:0] dataOut;
  logic             restoreOut;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;
  logic             overflow;
  logic             underflow;

  modport master (
    output backup, restore, clearErr, dataIn,
    input  dataOut, restoreOut, count, full, empty, overflow, underflow
  );

  modport slave (
    input  backup, restore, clearErr, dataIn,
    output dataOut, restoreOut, count, full, empty, overflow, underflow
  );
endinterface

// File: rtl/reg_snapshot_stack.sv
// Parametrised LIFO of register-file snapshots for nested call/interrupt
// context. A backup pushes the live image, a restore pops the saved image
// onto dataOut one cycle later; backup and restore together swap the top.
//
// Ports:
//   clk      in   single rising-edge clock
//   reset    in   synchronous active-high reset, priority over all inputs
//   stackIf  slave modport of reg_snapshot_stack_if carrying the
//            backup/restore/clearErr/dataIn requests and the
//            dataOut/restoreOut/count/full/empty/overflow/underflow results
//
// Parameters:
//   WIDTH  snapshot width in bits
//   DEPTH  number of snapshot slots (need not be a power of two)
//   WRAP   0 = reject a push when full, 1 = overwrite the oldest entry
//   CW     width of count
module reg_snapshot_stack #(
  parameter int WIDTH = 256,
  parameter int DEPTH = 16,
  parameter bit WRAP  = 1'b0,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  reg_snapshot_stack_if.slave stackIf
);

  localparam int            PW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST_SLOT  = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  // Decoded operation for the current edge.
  typedef enum logic [2:0] {
    OP_IDLE,
    OP_PUSH,
    OP_PUSH_FULL,
    OP_POP,
    OP_POP_EMPTY,
    OP_SWAP,
    OP_PASS
  } op_e;

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [PW-1:0]    top_q, top_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] dataOut_q, dataOut_d;
  logic             restoreOut_q, restoreOut_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic             memWe;
  logic [PW-1:0]    memAddr;
  logic [WIDTH-1:0] memWData;

  logic [PW-1:0]    topInc;
  logic [PW-1:0]    topDec;
  logic             isFull;
  logic             isEmpty;
  op_e              op;

  assign isFull  = (count_q == FULL_COUNT);
  assign isEmpty = (count_q == '0);

  // top wraps explicitly so DEPTH need not be a power of two.
  assign topInc = (top_q == LAST_SLOT) ? '0 : top_q + PW'(1);
  assign topDec = (top_q == '0) ? LAST_SLOT : top_q - PW'(1);

  // Classify the request against the current occupancy.
  always_comb begin
    op = OP_IDLE;
    case ({stackIf.backup, stackIf.restore})
      2'b10:   op = isFull  ? OP_PUSH_FULL : OP_PUSH;
      2'b01:   op = isEmpty ? OP_POP_EMPTY : OP_POP;
      2'b11:   op = isEmpty ? OP_PASS      : OP_SWAP;
      default: op = OP_IDLE;
    endcase
  end

  // Next-state computation. Sticky flags start from their cleared value when
  // clearErr is high so that an error event in the same cycle still wins.
  always_comb begin
    top_d        = top_q;
    count_d      = count_q;
    dataOut_d    = dataOut_q;
    restoreOut_d = 1'b0;
    overflow_d   = stackIf.clearErr ? 1'b0 : overflow_q;
    underflow_d  = stackIf.clearErr ? 1'b0 : underflow_q;
    memWe        = 1'b0;
    memAddr      = top_q;
    memWData     = stackIf.dataIn;

    case (op)
      OP_PUSH: begin
        memWe   = 1'b1;
        top_d   = topInc;
        count_d = count_q + CW'(1);
      end
      OP_PUSH_FULL: begin
        overflow_d = 1'b1;
        // When full, the slot at top is the oldest entry, so wrapping simply
        // writes there and advances top while count stays at DEPTH.
        if (WRAP) begin
          memWe = 1'b1;
          top_d = topInc;
        end
      end
      OP_POP: begin
        dataOut_d    = mem_q[topDec];
        top_d        = topDec;
        count_d      = count_q - CW'(1);
        restoreOut_d = 1'b1;
      end
      OP_POP_EMPTY: begin
        underflow_d = 1'b1;
      end
      OP_SWAP: begin
        dataOut_d    = mem_q[topDec];
        memWe        = 1'b1;
        memAddr      = topDec;
        restoreOut_d = 1'b1;
      end
      OP_PASS: begin
        dataOut_d    = stackIf.dataIn;
        restoreOut_d = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Control and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      top_q        <= '0;
      count_q      <= '0;
      dataOut_q    <= '0;
      restoreOut_q <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      top_q        <= top_d;
      count_q      <= count_d;
      dataOut_q    <= dataOut_d;
      restoreOut_q <= restoreOut_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
    end
  end

  // Snapshot storage is deliberately left out of reset; a write is gated off
  // during reset so an interrupted burst cannot corrupt a slot.
  always_ff @(posedge clk) begin
    if (memWe && !reset) begin
      mem_q[memAddr] <= memWData;
    end
  end

  assign stackIf.dataOut    = dataOut_q;
  assign stackIf.restoreOut = restoreOut_q;
  assign stackIf.count      = count_q;
  assign stackIf.full       = isFull;
  assign stackIf.empty      = isEmpty;
  assign stackIf.overflow   = overflow_q;
  assign stackIf.underflow  = underflow_q;

endmodule

// File: tb/tb_reg_snapshot_stack.sv
// Testbench for reg_snapshot_stack. Two instances share one stimulus stream:
// dutA rejects pushes when full, dutB overwrites the oldest entry. Each has a
// queue-based reference model; directed steps cover the reset, fill/drain,
// overflow, underflow, swap, pass-through and mid-burst reset cases, followed
// by a randomized phase.
module tb_reg_snapshot_stack;

  localparam int WIDTH = 256;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH + 1);

  typedef logic [WIDTH-1:0] snap_t;
  typedef snap_t snapQ_t[$];

  logic clk;
  logic reset;

  reg_snapshot_stack_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) ifA ();
  reg_snapshot_stack_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) ifB ();

  reg_snapshot_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH), .WRAP(1'b0)) dutA (
    .clk     (clk),
    .reset   (reset),
    .stackIf (ifA.slave)
  );

  reg_snapshot_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH), .WRAP(1'b1)) dutB (
    .clk     (clk),
    .reset   (reset),
    .stackIf (ifB.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passCount  = 0;
  int failCount  = 0;
  int totalCount = 0;
  int stepNo     = 0;

  // Reference model state: queue back is the top of the stack.
  snapQ_t qA;
  snapQ_t qB;
  snap_t  mOut [2];
  bit     mRo  [2];
  bit     mOv  [2];
  bit     mUf  [2];

  // Single comparison point; every check in the bench goes through here.
  task automatic checkVal(input string tag, input snap_t observed, input snap_t expected);
    totalCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Apply one edge of the stack rules to model idx.
  task automatic modelStep(input int idx, input bit wrap, input bit rst, input bit b,
                           input bit r, input bit clr, input snap_t din);
    snapQ_t q;
    if (idx == 0) q = qA; else q = qB;
    if (rst) begin
      q.delete();
      mOut[idx] = '0;
      mRo[idx]  = 1'b0;
      mOv[idx]  = 1'b0;
      mUf[idx]  = 1'b0;
    end else begin
      mRo[idx] = 1'b0;
      if (clr) begin
        mOv[idx] = 1'b0;
        mUf[idx] = 1'b0;
      end
      if (b && !r) begin
        if (q.size() < DEPTH) begin
          q.push_back(din);
        end else begin
          mOv[idx] = 1'b1;
          if (wrap) begin
            void'(q.pop_front());
            q.push_back(din);
          end
        end
      end else if (!b && r) begin
        if (q.size() > 0) begin
          mOut[idx] = q.pop_back();
          mRo[idx]  = 1'b1;
        end else begin
          mUf[idx] = 1'b1;
        end
      end else if (b && r) begin
        if (q.size() > 0) begin
          mOut[idx] = q[q.size() - 1];
          q[q.size() - 1] = din;
        end else begin
          mOut[idx] = din;
        end
        mRo[idx] = 1'b1;
      end
    end
    if (idx == 0) qA = q; else qB = q;
  endtask

  // Compare every output of both instances with their models.
  task automatic checkOutput();
    for (int idx = 0; idx < 2; idx++) begin
      snap_t        dOut;
      logic         ro, fu, em, ov, uf;
      logic [CW-1:0] cnt;
      int           sz;
      string        n;
      if (idx == 0) begin
        dOut = ifA.dataOut; ro = ifA.restoreOut; cnt = ifA.count;
        fu = ifA.full; em = ifA.empty; ov = ifA.overflow; uf = ifA.underflow;
        sz = qA.size(); n = "A";
      end else begin
        dOut = ifB.dataOut; ro = ifB.restoreOut; cnt = ifB.count;
        fu = ifB.full; em = ifB.empty; ov = ifB.overflow; uf = ifB.underflow;
        sz = qB.size(); n = "B";
      end
      checkVal($sformatf("%s.dataOut step%0d", n, stepNo), dOut, mOut[idx]);
      checkVal($sformatf("%s.restoreOut step%0d", n, stepNo), snap_t'(ro), snap_t'(mRo[idx]));
      checkVal($sformatf("%s.count step%0d", n, stepNo), snap_t'(cnt), snap_t'(sz));
      checkVal($sformatf("%s.full step%0d", n, stepNo), snap_t'(fu), snap_t'(sz == DEPTH));
      checkVal($sformatf("%s.empty step%0d", n, stepNo), snap_t'(em), snap_t'(sz == 0));
      checkVal($sformatf("%s.overflow step%0d", n, stepNo), snap_t'(ov), snap_t'(mOv[idx]));
      checkVal($sformatf("%s.underflow step%0d", n, stepNo), snap_t'(uf), snap_t'(mUf[idx]));
    end
  endtask

  // Drive one cycle of inputs into both instances, advance both models at the
  // edge, then check outputs one time unit later.
  task automatic applyStimulus(input bit rst, input bit b, input bit r,
                               input bit clr, input snap_t din);
    reset        = rst;
    ifA.backup   = b;   ifB.backup   = b;
    ifA.restore  = r;   ifB.restore  = r;
    ifA.clearErr = clr; ifB.clearErr = clr;
    ifA.dataIn   = din; ifB.dataIn   = din;
    @(posedge clk);
    modelStep(0, 1'b0, rst, b, r, clr, din);
    modelStep(1, 1'b1, rst, b, r, clr, din);
    #1;
    stepNo++;
    checkOutput();
  endtask

  function automatic snap_t randData();
    snap_t d;
    for (int w = 0; w < WIDTH / 32; w++) d[w*32 +: 32] = $urandom;
    return d;
  endfunction

  initial begin
    reset = 1'b1;
    ifA.backup = 1'b0; ifA.restore = 1'b0; ifA.clearErr = 1'b0; ifA.dataIn = '0;
    ifB.backup = 1'b0; ifB.restore = 1'b0; ifB.clearErr = 1'b0; ifB.dataIn = '0;

    // Reset state.
    applyStimulus(1, 0, 0, 0, '0);
    applyStimulus(1, 0, 0, 0, '0);
    checkVal("reset.empty", snap_t'(ifA.empty), snap_t'(1));
    checkVal("reset.count", snap_t'(ifA.count), snap_t'(0));
    applyStimulus(0, 0, 0, 0, '0);

    // Fill with 0..15, then push 99 into the full stack.
    for (int i = 0; i < DEPTH; i++) applyStimulus(0, 1, 0, 0, snap_t'(i));
    checkVal("fill.full", snap_t'(ifA.full), snap_t'(1));
    applyStimulus(0, 1, 0, 0, snap_t'(99));
    checkVal("reject.overflow", snap_t'(ifA.overflow), snap_t'(1));
    checkVal("reject.count", snap_t'(ifA.count), snap_t'(16));
    checkVal("wrap99.overflow", snap_t'(ifB.overflow), snap_t'(1));

    // Drain with restore held; rejecting stack returns 15..0.
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(0, 0, 1, 0, '0);
      checkVal($sformatf("drain.dataOut%0d", i), ifA.dataOut, snap_t'(15 - i));
      checkVal($sformatf("drain.restoreOut%0d", i), snap_t'(ifA.restoreOut), snap_t'(1));
    end
    checkVal("drain.empty", snap_t'(ifA.empty), snap_t'(1));
    applyStimulus(0, 0, 0, 1, '0);
    checkVal("clear.overflow", snap_t'(ifA.overflow), snap_t'(0));

    // Wrap: push 0..17 and pop 16; wrapping stack returns 17..2.
    for (int i = 0; i < DEPTH + 2; i++) applyStimulus(0, 1, 0, 0, snap_t'(i));
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(0, 0, 1, 0, '0);
      checkVal($sformatf("wrap.dataOut%0d", i), ifB.dataOut, snap_t'(17 - i));
    end
    checkVal("wrap.overflow", snap_t'(ifB.overflow), snap_t'(1));
    checkVal("wrap.empty", snap_t'(ifB.empty), snap_t'(1));

    // Pop on empty.
    applyStimulus(0, 0, 0, 1, '0);
    applyStimulus(0, 0, 1, 0, '0);
    checkVal("under.flag", snap_t'(ifA.underflow), snap_t'(1));
    checkVal("under.restoreOut", snap_t'(ifA.restoreOut), snap_t'(0));
    checkVal("under.dataOut", ifA.dataOut, snap_t'(0));

    // Swap and pass-through.
    applyStimulus(0, 1, 0, 1, snap_t'(5));
    applyStimulus(0, 1, 1, 0, snap_t'(7));
    checkVal("swap.dataOut", ifA.dataOut, snap_t'(5));
    checkVal("swap.count", snap_t'(ifA.count), snap_t'(1));
    applyStimulus(0, 0, 1, 0, '0);
    checkVal("swap.popped", ifA.dataOut, snap_t'(7));
    applyStimulus(0, 1, 1, 0, snap_t'(3));
    checkVal("pass.dataOut", ifA.dataOut, snap_t'(3));
    checkVal("pass.count", snap_t'(ifA.count), snap_t'(0));

    // Reset in the middle of a restore burst.
    for (int i = 0; i < 10; i++) applyStimulus(0, 1, 0, 0, snap_t'(i));
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 0, '0);
    applyStimulus(1, 0, 1, 0, '0);
    checkVal("midreset.count", snap_t'(ifA.count), snap_t'(0));
    checkVal("midreset.dataOut", ifA.dataOut, snap_t'(0));
    applyStimulus(0, 1, 0, 0, snap_t'(42));
    applyStimulus(0, 0, 1, 0, '0);
    checkVal("midreset.pop42", ifA.dataOut, snap_t'(42));

    // Randomized phase, biased so both full and empty regions are visited.
    for (int i = 0; i < 600; i++) begin
      bit    rst, b, r, clr;
      int    sel;
      sel = (i / 100) % 2;
      rst = ($urandom_range(0, 99) == 0);
      clr = ($urandom_range(0, 7) == 0);
      b   = (sel == 0) ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 9) < 3);
      r   = (sel == 0) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 7);
      applyStimulus(rst, b, r, clr, randData());
    end

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule

// File: doc/reg_snapshot_stack.md
# reg_snapshot_stack

Parametrised LIFO that stores register-file snapshots for nested call/interrupt context. It is the generalised successor to the fixed 16-deep, 256-bit f-register backup stack. Width, depth and overflow policy are configurable, and it adds occupancy and error status plus defined simultaneous push/pop behaviour. It sits beside the register file: `backup` pushes the live file image, and `restore` pops the saved image back onto `dataOut`.

## Interface
- `WIDTH`, 256: snapshot width in bits (≥1).
- `DEPTH`, 16: number of snapshot slots (≥2, power of two not required).
- `WRAP`, 0: overflow policy. 0 = reject push when full; 1 = overwrite oldest entry.
- `CW`, $clog2(DEPTH+1): width of `count`.
- `clk` in 1: single clock, all state updates on rising edge.
- `reset` in 1: synchronous, active-high reset.
- `backup` in 1: push `dataIn` this cycle (level; one push per cycle while high).
- `restore` in 1: pop top entry this cycle (level; one pop per cycle while high).
- `clearErr` in 1: clear sticky error flags.
- `dataIn` in WIDTH: snapshot to push.
- `dataOut` out WIDTH: registered popped snapshot; holds value until next pop.
- `restoreOut` out 1: one-cycle pulse, `dataOut` updated this cycle.
- `count` out CW: current occupancy, 0..DEPTH.
- `full` out 1: `count == DEPTH`.
- `empty` out 1: `count == 0`.
- `overflow` out 1: sticky; a push was rejected, or in WRAP mode an entry was overwritten.
- `underflow` out 1: sticky; a pop occurred on empty.

## Operation
- Storage: DEPTH×WIDTH array addressed circularly by `top` pointer (index of next free slot) and `count`. Array contents are not reset.
- Per edge, decoded from {backup, restore} with current `count`:
  - 00: idle; `restoreOut`=0.
  - 10, not full: write `dataIn` at `top`; `top`+1 mod DEPTH; `count`+1.
  - 10, full, WRAP=0: no write, state unchanged, set `overflow`.
  - 10, full, WRAP=1: write at `top` (oldest slot), `top`+1 mod DEPTH, `count` stays DEPTH, set `overflow`.
  - 01, not empty: `dataOut` ← entry at `top`-1; `top`-1 mod DEPTH; `count`-1; `restoreOut`=1.
  - 01, empty: `dataOut` unchanged, `restoreOut`=0, set `underflow`.
  - 11, not empty: swap. `dataOut` ← entry at `top`-1; same slot ← `dataIn`; `count` and `top` unchanged; `restoreOut`=1. No error, even when full.
  - 11, empty: pass-through. `dataOut` ← `dataIn`; `restoreOut`=1; `count` stays 0; no error.
- `full` and `empty` are combinational from registered `count`.
- `clearErr` clears both sticky flags. If an error event occurs in the same cycle, the event wins and the flag is set.
- `reset` has priority over all inputs, including mid-burst.

## Timing
- Reset values: `dataOut`=0, `restoreOut`=0, `count`=0, `top`=0, `overflow`=0, `underflow`=0, therefore `full`=0 and `empty`=1.
- Pop latency is 1 cycle. `restore` sampled at edge N gives `dataOut` and `restoreOut` valid after edge N, through edge N+1.
- A push at edge N is visible to a pop at edge N+1 (back-to-back push/pop returns the just-pushed value).
- `count`, `full` and `empty` reflect the operation performed at the previous edge.
- Throughput: one push, one pop, or one swap per cycle, sustained.

## Test plan
- Defaults (WIDTH=256, DEPTH=16, WRAP=0). After reset, push 0..15 on consecutive cycles, then hold `restore` 16 cycles. Required: `full`=1 after 16th push; `dataOut` sequence is 15,14,…,0, with `restoreOut` high each cycle; ends with `empty`=1 and `count`=0.
- WRAP=0, full with 0..15: push 99. Required: `overflow`=1, `count`=16, next pop returns 15. Then `clearErr` gives `overflow`=0.
- WRAP=1, DEPTH=16: push 0..17, then pop 16 times. Required: returns 17..2, `overflow`=1, `empty`=1 at end.
- Empty stack, assert `restore`. Required: `underflow`=1, `restoreOut`=0, `dataOut` unchanged, `count`=0.
- Push 5, then {backup, restore}=11 with `dataIn`=7. Required: `dataOut`=5, `restoreOut`=1, `count`=1; next pop returns 7. Repeat 11 on empty with `dataIn`=3: `dataOut`=3, `count`=0.
- Push 0..9, assert `reset` during a `restore` burst. Required: following edge shows `count`=0, `empty`=1, `dataOut`=0, `restoreOut`=0, flags 0; next push/pop of 42 returns 42.
